// File: rtl/uart_piso_tx.sv
// rtl/uart_piso_tx.sv - UART transmit serializer with a one-entry holding register
module uart_piso_tx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 baud_clk_tx,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_tx,
  input  logic                 valid_tx,
  output logic                 ready_tx,
  output logic                 serial_data_tx,
  output logic                 active_flag_tx,
  output logic                 sent_flag
);

  // Frame = start + data + parity + stop.
  localparam int FRAME_BITS = DATA_BITS + 3;
  // The counter only has to reach DATA_BITS+2, i.e. FRAME_BITS-1.
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS + 2);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
  logic                  hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  serial_q, serial_d;
  logic                  ready_q, ready_d;
  logic                  active_q, active_d;
  logic                  sent_q, sent_d;

  logic                  accept;
  logic                  load;
  logic                  parity_bit;
  logic [FRAME_BITS-1:0] frame;

  // Handshake and the frame image built from the holding register.
  always_comb begin
    accept     = valid_tx & ready_q;
    parity_bit = (^hold_data_q) ^ PARITY_ODD;
    frame      = {1'b1, parity_bit, hold_data_q, 1'b0};
  end

  // Next-state logic: holding register, frame sequencing and registered outputs.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    serial_d    = serial_q;
    sent_d      = 1'b0;
    load        = 1'b0;

    // Accept never coincides with a load: ready is low whenever the holder is full.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = data_tx;
    end

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_CNT) begin
          // Stop bit has been on the line for a full period.
          sent_d = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            serial_d  = 1'b1;
            bit_cnt_d = '0;
          end
        end else begin
          serial_d  = shift_q[0];
          shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Start bit goes straight to the line; the rest waits in the shifter.
    if (load) begin
      serial_d    = frame[0];
      shift_d     = {1'b1, frame[FRAME_BITS-1:1]};
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
      state_d     = ST_SHIFT;
    end

    // Ready stays low on the load edge and recovers one edge later.
    ready_d  = ~hold_full_q & ~accept;
    active_d = (state_d == ST_SHIFT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge baud_clk_tx) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '1;
      bit_cnt_q   <= '0;
      serial_q    <= 1'b1;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
      sent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      serial_q    <= serial_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      sent_q      <= sent_d;
    end
  end

  assign ready_tx       = ready_q;
  assign serial_data_tx = serial_q;
  assign active_flag_tx = active_q;
  assign sent_flag      = sent_q;

endmodule

// File: tb/tb_uart_piso_tx.sv
// tb/tb_uart_piso_tx.sv - self-checking bench for uart_piso_tx (even and odd parity instances)
module tb_uart_piso_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_tx = 8'h00;
  logic       valid_tx = 1'b0;

  logic rdy_e, ser_e, act_e, sent_e;
  logic rdy_o, ser_o, act_o, sent_o;

  int errors = 0;
  int checks = 0;

  uart_piso_tx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut_e (
    .baud_clk_tx   (clk),
    .rst           (rst),
    .data_tx       (data_tx),
    .valid_tx      (valid_tx),
    .ready_tx      (rdy_e),
    .serial_data_tx(ser_e),
    .active_flag_tx(act_e),
    .sent_flag     (sent_e)
  );

  uart_piso_tx #(.DATA_BITS(8), .PARITY_ODD(1'b1)) dut_o (
    .baud_clk_tx   (clk),
    .rst           (rst),
    .data_tx       (data_tx),
    .valid_tx      (valid_tx),
    .ready_tx      (rdy_o),
    .serial_data_tx(ser_o),
    .active_flag_tx(act_o),
    .sent_flag     (sent_o)
  );

  always #5 clk = ~clk;

  // {serial, ready, active, sent} for even instance, then odd instance.
  wire [7:0] obs = {ser_e, rdy_e, act_e, sent_e, ser_o, rdy_o, act_o, sent_o};

  // Reference model: a queue of line bits fed one frame at a time.
  bit         line_e[$];
  bit         line_o[$];
  bit         line_last[$];
  bit         m_hold = 1'b0;
  bit         m_ready = 1'b1;
  bit         m_stop_prev = 1'b0;
  bit         m_acc = 1'b0;
  bit         m_loaded = 1'b0;
  logic [7:0] m_hold_data = 8'h00;
  logic [7:0] m_exp = 8'hCC;

  // Advance the model one baud edge.
  always @(posedge clk) begin : model
    bit se, so, a, s, par;
    if (rst) begin
      line_e.delete();
      line_o.delete();
      line_last.delete();
      m_hold = 1'b0;
      m_ready = 1'b1;
      m_stop_prev = 1'b0;
      m_acc = 1'b0;
      m_loaded = 1'b0;
      m_exp = 8'hCC;
    end else begin
      m_acc = valid_tx && m_ready;
      m_loaded = 1'b0;
      if (line_e.size() == 0 && m_hold) begin
        par = (($countones(m_hold_data) % 2) == 1);
        line_e.push_back(1'b0); line_o.push_back(1'b0); line_last.push_back(1'b0);
        for (int k = 0; k < 8; k++) begin
          line_e.push_back(m_hold_data[k]);
          line_o.push_back(m_hold_data[k]);
          line_last.push_back(1'b0);
        end
        line_e.push_back(par); line_o.push_back(!par); line_last.push_back(1'b0);
        line_e.push_back(1'b1); line_o.push_back(1'b1); line_last.push_back(1'b1);
        m_hold = 1'b0;
        m_loaded = 1'b1;
      end
      if (m_acc) begin
        m_hold = 1'b1;
        m_hold_data = data_tx;
      end
      s = m_stop_prev;
      m_stop_prev = 1'b0;
      if (line_e.size() > 0) begin
        se = line_e.pop_front();
        so = line_o.pop_front();
        m_stop_prev = line_last.pop_front();
        a = 1'b1;
      end else begin
        se = 1'b1;
        so = 1'b1;
        a = 1'b0;
      end
      m_ready = !m_hold && !m_loaded;
      m_exp = {se, m_ready, a, s, so, m_ready, a, s};
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    valid_tx = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 8'hCC) begin
        errors++;
        $display("FAIL reset_state got=%b exp=%b", obs, 8'hCC);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 8'hCC) begin
        errors++;
        $display("FAIL idle_after_reset cycle=%0d got=%b exp=%b", i, obs, 8'hCC);
      end
    end
  endtask

  task automatic test_single_a5();
    logic [10:0] seq_e, seq_o;
    int sent_cnt = 0;
    int sent_at = -1;
    valid_tx = 1'b1;
    data_tx = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (m_acc) valid_tx = 1'b0;
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL single_model cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
      if (i >= 1 && i <= 11) begin
        seq_e[i-1] = ser_e;
        seq_o[i-1] = ser_o;
      end
      if (sent_e) begin
        sent_cnt++;
        sent_at = i;
      end
    end
    checks++;
    if (seq_e !== 11'b1_0_10100101_0) begin
      errors++;
      $display("FAIL single_a5_even_line got=%b exp=%b", seq_e, 11'b1_0_10100101_0);
    end
    checks++;
    if (seq_o !== 11'b1_1_10100101_0) begin
      errors++;
      $display("FAIL single_a5_odd_line got=%b exp=%b", seq_o, 11'b1_1_10100101_0);
    end
    checks++;
    if (sent_cnt != 1 || sent_at != 12) begin
      errors++;
      $display("FAIL single_sent_pulse got count=%0d at=%0d exp count=1 at=12", sent_cnt, sent_at);
    end
  endtask

  task automatic test_parity();
    logic [7:0] vals [2] = '{8'hFF, 8'h00};
    for (int v = 0; v < 2; v++) begin
      logic par_e = 1'bx;
      logic par_o = 1'bx;
      valid_tx = 1'b1;
      data_tx = vals[v];
      for (int i = 0; i < 14; i++) begin
        @(posedge clk); #1;
        if (m_acc) valid_tx = 1'b0;
        checks++;
        if (obs !== m_exp) begin
          errors++;
          $display("FAIL parity_model data=%h cycle=%0d got=%b exp=%b", vals[v], i, obs, m_exp);
        end
        if (i == 10) begin
          par_e = ser_e;
          par_o = ser_o;
        end
      end
      checks++;
      if (par_e !== 1'b0) begin
        errors++;
        $display("FAIL parity_even data=%h got=%b exp=0", vals[v], par_e);
      end
      checks++;
      if (par_o !== 1'b1) begin
        errors++;
        $display("FAIL parity_odd data=%h got=%b exp=1", vals[v], par_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] seq_e, seq_o;
    logic [26:0] sent_vec = '0;
    int n_acc = 0;
    valid_tx = 1'b1;
    data_tx = 8'h01;
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      if (m_acc) begin
        n_acc++;
        if (n_acc == 1) data_tx = 8'h80;
        else valid_tx = 1'b0;
      end
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL b2b_model cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
      if (i >= 1 && i <= 22) begin
        seq_e[i-1] = ser_e;
        seq_o[i-1] = ser_o;
      end
      sent_vec[i] = sent_e;
    end
    checks++;
    if (seq_e !== {11'b1_1_10000000_0, 11'b1_1_00000001_0}) begin
      errors++;
      $display("FAIL b2b_even_line got=%b exp=%b", seq_e, {11'b1_1_10000000_0, 11'b1_1_00000001_0});
    end
    checks++;
    if (seq_o !== {11'b1_0_10000000_0, 11'b1_0_00000001_0}) begin
      errors++;
      $display("FAIL b2b_odd_line got=%b exp=%b", seq_o, {11'b1_0_10000000_0, 11'b1_0_00000001_0});
    end
    checks++;
    if (sent_vec !== ((27'd1 << 12) | (27'd1 << 23))) begin
      errors++;
      $display("FAIL b2b_sent_pulses got=%b exp=%b", sent_vec, ((27'd1 << 12) | (27'd1 << 23)));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] seq_e, seq_o;
    int sent_cnt = 0;
    int ones = 0;
    valid_tx = 1'b1;
    data_tx = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_acc) valid_tx = 1'b0;
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL midrst_pre_model cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (obs !== 8'hCC) begin
      errors++;
      $display("FAIL midrst_reset_edge got=%b exp=%b", obs, 8'hCC);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (sent_e || sent_o) sent_cnt++;
      if (ser_e && ser_o) ones++;
    end
    checks++;
    if (sent_cnt != 0 || ones != 15) begin
      errors++;
      $display("FAIL midrst_quiet got sent=%0d idle_ones=%0d exp sent=0 idle_ones=15", sent_cnt, ones);
    end
    valid_tx = 1'b1;
    data_tx = 8'h55;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (m_acc) valid_tx = 1'b0;
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL midrst_resend_model cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
      if (i >= 1 && i <= 11) begin
        seq_e[i-1] = ser_e;
        seq_o[i-1] = ser_o;
      end
    end
    checks++;
    if (seq_e !== 11'b1_0_01010101_0 || seq_o !== 11'b1_1_01010101_0) begin
      errors++;
      $display("FAIL midrst_resend_line got=%b/%b exp=%b/%b", seq_e, seq_o,
               11'b1_0_01010101_0, 11'b1_1_01010101_0);
    end
  endtask

  task automatic test_handshake_stall();
    bit         line_arr[48];
    int         load_idx[$];
    logic [7:0] acc_val[$];
    logic [7:0] payload;
    valid_tx = 1'b1;
    data_tx = 8'($urandom);
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (m_acc) acc_val.push_back(data_tx);
      if (m_loaded) load_idx.push_back(i);
      if (acc_val.size() >= 3) valid_tx = 1'b0;
      else data_tx = 8'($urandom);
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL stall_model cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
      line_arr[i] = ser_e;
    end
    checks++;
    if (load_idx.size() < 3 || acc_val.size() < 3) begin
      errors++;
      $display("FAIL stall_frames got loads=%0d accepts=%0d exp 3", load_idx.size(), acc_val.size());
    end else begin
      for (int f = 1; f < 3; f++) begin
        for (int k = 0; k < 8; k++) payload[k] = line_arr[load_idx[f] + 1 + k];
        checks++;
        if (payload !== acc_val[f]) begin
          errors++;
          $display("FAIL stall_payload frame=%0d got=%h exp=%h", f, payload, acc_val[f]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL random_model cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
      if (!valid_tx || m_acc) begin
        valid_tx = ($urandom_range(0, 3) != 0);
        data_tx = 8'($urandom);
      end
    end
    valid_tx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== m_exp) begin
        errors++;
        $display("FAIL random_drain cycle=%0d got=%b exp=%b", i, obs, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_handshake_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_piso_tx.md
# uart_piso_tx

UART transmitter serializer: accepts one data byte through a valid/ready handshake and shifts out an 11-bit frame on `serial_data_tx`, one bit per baud clock. The frame is start bit 0, 8 data bits LSB first, 1 parity bit, and stop bit 1. It sits directly upstream of the SIPO receiver and drives that receiver's serial input. It includes a one-entry holding register, so the next byte can be accepted while the current frame is shifting, and back-to-back frames leave no idle gap.

## Interface
- `DATA_BITS`, default 8: data bits per frame. The frame length is `DATA_BITS+3` (11 at default).
- `PARITY_ODD`, default 0: selects the parity type.
  - 0: even parity; the parity bit is the XOR of the data bits.
  - 1: odd parity; the parity bit is the inverted XOR.
- `baud_clk_tx` in, 1 bit: bit-rate clock; one serial bit per rising edge.
- `rst` in, 1 bit: synchronous reset, active-high.
- `data_tx` in, `DATA_BITS` wide: byte to send; sampled on accept.
- `valid_tx` in, 1 bit: `data_tx` is valid.
- `ready_tx` out, 1 bit: holding register is empty and a byte can be accepted. Registered.
- `serial_data_tx` out, 1 bit: serial line. Idle level is 1. Registered.
- `active_flag_tx` out, 1 bit: high while a frame is on the line (start bit through stop bit).
- `sent_flag` out, 1 bit: one-cycle pulse when a frame's stop bit period completes.

## Operation
- Holding register (`hold_data`, `hold_full`):
  - A byte is accepted on an edge where `valid_tx & ready_tx & ~rst`. That edge sets `hold_full`.
  - `ready_tx = ~hold_full`, registered.
- State machine:
  - IDLE:
    - `serial_data_tx=1`, `active_flag_tx=0`.
    - If `hold_full` on an edge: load the shift register with `{1, parity, data, 0}` (start bit 0 shifts out first), clear `hold_full`, drive start bit, go to SHIFT with `bit_cnt=0`.
  - SHIFT:
    - Each edge drives the next frame bit, LSB first, and increments `bit_cnt`.
    - After the stop bit has been on the line for one full cycle (the edge at `bit_cnt = DATA_BITS+2`), pulse `sent_flag`.
    - On that same edge, if `hold_full`: load the next frame and drive its start bit. `active_flag_tx` stays 1.
    - Otherwise go to IDLE: `serial_data_tx=1`, `active_flag_tx=0`.
- Parity is computed from `hold_data` at load time. Later changes to `data_tx` do not affect the frame in flight.
- Simultaneous events:
  - The load edge and the accept edge never coincide, because `ready_tx` is 0 when `hold_full`.
  - `ready_tx` returns to 1 on the edge after the load.
- `valid_tx` is ignored while `ready_tx=0`. The upstream must hold `valid_tx` and `data_tx` until it sees `ready_tx=1` at an edge.
- Reset mid-frame:
  - The frame is aborted and the holding register is discarded.
  - No `sent_flag` is produced.
  - The line returns to 1 on the reset edge.

## Timing
- Reset values (applied on any edge with `rst=1`):
  - `serial_data_tx=1`, `ready_tx=1`, `active_flag_tx=0`, `sent_flag=0`
  - `hold_full=0`, state IDLE, `bit_cnt=0`
- From IDLE, with the accept at edge N:
  - `ready_tx=0` after N.
  - Start bit appears after edge N+1, and `ready_tx=1` again after N+2.
  - Data bit k appears after edge N+2+k.
  - Parity appears after edge N+10.
  - Stop bit appears after edge N+11.
  - `sent_flag=1` after edge N+12 for exactly one cycle.
- Line occupancy is exactly 11 bit periods per frame.
- Back-to-back frames: the next start bit follows the stop bit directly, so sustained throughput is 1 frame per 11 cycles.
- With the receiver's 9600-baud clock (period 104166.7 ns at 1 ns units, or the scaled bench period), each bit is held for exactly one `baud_clk_tx` period.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst=1` for 2 edges, release, keep `valid_tx=0` for 20 edges.
  - Required: `serial_data_tx=1`, `ready_tx=1`, `active_flag_tx=0`, `sent_flag=0` throughout.
- Single frame, 0xA5 with `PARITY_ODD=0`:
  - Stimulus: accept 0xA5.
  - Required: line sequence 0,1,0,1,0,0,1,0,1,0,1 starting at edge N+1. `sent_flag` pulses once at N+12, then the line stays at 1.
- Parity variants:
  - Stimulus: send 0xFF and 0x00 with `PARITY_ODD=0`, then repeat with `PARITY_ODD=1`.
  - Required: with even parity, the parity bit is 0 for both 0xFF and 0x00. With odd parity, the parity bit is 1 for both.
- Back-to-back frames:
  - Stimulus: keep `valid_tx=1`, presenting 0x01 then 0x80.
  - Required: 22 consecutive bits: 0,1,0000000,1,1 followed by 0,0000000,1,1,1. No idle bit between frames. `ready_tx` drops on each accept and returns 1 the edge after each load. `sent_flag` pulses at N+12 and N+23.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 edge during data bit 3 of 0x3C.
  - Required: the line is 1 on the reset edge, with no `sent_flag` and no further frame bits. A subsequent send of 0x55 is transmitted correctly.
- Handshake stall:
  - Stimulus: while frame 1 is shifting and the holding register is full, change `data_tx` with `valid_tx=1`.
  - Required: the changed value is not accepted until `ready_tx=1`, and the frame 2 payload equals the value presented at that accepting edge.
